// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM controller slice.
package sdram_pkg;

  localparam int unsigned W_CALL     = 4;
  localparam int unsigned W_REF      = 14;
  localparam int unsigned W_ADDR_DEF = 24;
  localparam int unsigned W_DATA_DEF = 16;

  localparam logic [W_REF-1:0] TREF_DEF = 14'd1040;

  // One-hot calls to the function module
  localparam logic [W_CALL-1:0] CALL_NONE = 4'b0000;
  localparam logic [W_CALL-1:0] CALL_WR   = 4'b1000;
  localparam logic [W_CALL-1:0] CALL_RD   = 4'b0100;
  localparam logic [W_CALL-1:0] CALL_REF  = 4'b0010;
  localparam logic [W_CALL-1:0] CALL_INIT = 4'b0001;

  // User address layout: bank / row / column
  localparam int unsigned BANK_MSB = 23;
  localparam int unsigned BANK_LSB = 22;
  localparam int unsigned ROW_MSB  = 21;
  localparam int unsigned ROW_LSB  = 9;
  localparam int unsigned COL_MSB  = 8;
  localparam int unsigned COL_LSB  = 0;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_REFRESH = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/sdram_reftimer.sv
// Auto-refresh interval timer with a sticky, saturating pending flag.
module sdram_reftimer
  import sdram_pkg::*;
#(
  parameter logic [W_REF-1:0] TREF = TREF_DEF
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic iEn,
  input  logic iClr,
  output logic oPend
);

  logic [W_REF-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             wrap_c;

  assign wrap_c = iEn && (cnt_q == TREF - W_REF'(1));

  // Next counter value and pending flag; a wrap wins over a clear
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (!iEn) begin
      cnt_d = '0;
    end else if (wrap_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W_REF'(1);
    end
    if (wrap_c) begin
      pend_d = 1'b1;
    end else if (iClr) begin
      pend_d = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign oPend = pend_q;

endmodule

// File: rtl/sdram_ctrlmod.sv
// Sequencer in front of sdram_funcmod: init, refresh scheduling, and
// write/read arbitration with a level-call / one-cycle-done handshake.
module sdram_ctrlmod
  import sdram_pkg::*;
#(
  parameter logic [W_REF-1:0] TREF   = TREF_DEF,
  parameter int unsigned      W_ADDR = W_ADDR_DEF,
  parameter int unsigned      W_DATA = W_DATA_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [1:0]        iCall,
  output logic              oDone,
  output logic              oReady,
  input  logic [W_ADDR-1:0] iAddr,
  input  logic [W_DATA-1:0] iData,
  output logic [W_DATA-1:0] oData,
  output logic [W_CALL-1:0] oFCall,
  input  logic              iFDone,
  output logic [W_ADDR-1:0] oFAddr,
  output logic [W_DATA-1:0] oFData,
  input  logic [W_DATA-1:0] iFData
);

  state_e            state_q, state_d;
  logic [W_CALL-1:0] fcall_q, fcall_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic [W_ADDR-1:0] faddr_q, faddr_d;
  logic [W_DATA-1:0] fdata_q, fdata_d;
  logic              ref_en_c;
  logic              ref_clr_c;
  logic              ref_pend;

  // Timer runs only once init has finished
  assign ref_en_c = (state_q != ST_INIT);

  sdram_reftimer #(
    .TREF (TREF)
  ) u_reftimer (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iEn   (ref_en_c),
    .iClr  (ref_clr_c),
    .oPend (ref_pend)
  );

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    fcall_d   = fcall_q;
    data_d    = data_q;
    faddr_d   = faddr_q;
    fdata_d   = fdata_q;
    ref_clr_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        fcall_d = CALL_INIT;
        // Ignore a done that arrives before the init call is actually out
        if (iFDone && (fcall_q == CALL_INIT)) begin
          fcall_d = CALL_NONE;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ref_pend) begin
          fcall_d   = CALL_REF;
          ref_clr_c = 1'b1;
          state_d   = ST_REFRESH;
        end else if (iCall[1]) begin
          faddr_d = iAddr;
          fdata_d = iData;
          fcall_d = CALL_WR;
          state_d = ST_WRITE;
        end else if (iCall[0]) begin
          faddr_d = iAddr;
          fcall_d = CALL_RD;
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (iFDone) begin
          fcall_d = CALL_NONE;
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (iFDone) begin
          fcall_d = CALL_NONE;
          data_d  = iFData;
          state_d = ST_DONE;
        end
      end
      ST_REFRESH: begin
        if (iFDone) begin
          fcall_d = CALL_NONE;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        fcall_d = CALL_NONE;
        state_d = ST_INIT;
      end
    endcase
    // Registered decodes so oDone/oReady line up with the state they describe
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_INIT;
      fcall_q <= CALL_NONE;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      fcall_q <= fcall_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign oFCall = fcall_q;
  assign oDone  = done_q;
  assign oReady = ready_q;
  assign oData  = data_q;
  assign oFAddr = faddr_q;
  assign oFData = fdata_q;

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Randomized bench for sdram_ctrlmod with a behavioural function module.
module tb_sdram_ctrlmod;
  import sdram_pkg::*;

  localparam int          TREF_I  = 60;
  localparam logic [13:0] TB_TREF = 14'd60;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  iCall;
  logic        oDone;
  logic        oReady;
  logic [23:0] iAddr;
  logic [15:0] iData;
  logic [15:0] oData;
  logic [3:0]  oFCall;
  logic        iFDone;
  logic [23:0] oFAddr;
  logic [15:0] oFData;
  logic [15:0] iFData;

  always #5 CLOCK = ~CLOCK;

  sdram_ctrlmod #(
    .TREF   (TB_TREF),
    .W_ADDR (24),
    .W_DATA (16)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .iCall  (iCall),
    .oDone  (oDone),
    .oReady (oReady),
    .iAddr  (iAddr),
    .iData  (iData),
    .oData  (oData),
    .oFCall (oFCall),
    .iFDone (iFDone),
    .oFAddr (oFAddr),
    .oFData (oFData),
    .iFData (iFData)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memories: fmem is what the function module stores, ref_mem is the user-side model
  logic [15:0] fmem    [logic [23:0]];
  logic [15:0] ref_mem [logic [23:0]];
  logic [23:0] addr_tab [8];

  // Function-module behavioural model
  int          force_lat = 0;
  logic [3:0]  fm_call;
  logic [23:0] fm_addr;
  logic [15:0] fm_data;
  int          fm_lat;
  bit          fm_abort;

  initial begin
    iFDone = 1'b0;
    iFData = 16'h0;
    forever begin
      @(negedge CLOCK);
      if (RESET === 1'b1 && oFCall != 4'b0) begin
        fm_call  = oFCall;
        fm_addr  = oFAddr;
        fm_data  = oFData;
        fm_lat   = (force_lat > 0) ? force_lat : ((fm_call == CALL_INIT) ? 20 : int'($urandom_range(2, 12)));
        fm_abort = 1'b0;
        for (int i = 0; i < fm_lat; i++) begin
          @(posedge CLOCK);
          if (RESET !== 1'b1) fm_abort = 1'b1;
        end
        if (!fm_abort) begin
          #1;
          if (fm_call == CALL_WR) fmem[fm_addr] = fm_data;
          if (fm_call == CALL_RD) iFData = fmem.exists(fm_addr) ? fmem[fm_addr] : 16'hDEAD;
          iFDone = 1'b1;
          @(posedge CLOCK);
          #1;
          iFDone = 1'b0;
        end
      end
    end
  end

  // Protocol monitor and scheduling reference model.
  // n counts cycles since the first IDLE cycle after init; a refresh is owed in
  // cycle m whenever a TREF boundary has passed since the one last served.
  bit         run = 1'b0;
  int         n = 0;
  int         consumed = 0;
  logic [3:0] prev_fcall = 4'b0;
  logic [1:0] prev_icall = 2'b0;
  logic       prev_fdone = 1'b0;
  logic [3:0] active = 4'b0;
  logic [3:0] last_user = 4'b0;
  logic [3:0] exp_call;
  logic       exp_done;
  logic [3:0] call_log [$];
  int         ref_times [$];
  int         done_cnt = 0;

  always @(negedge CLOCK) begin
    if (RESET !== 1'b1) begin
      run        = 1'b0;
      prev_fcall = 4'b0;
      prev_fdone = 1'b0;
      active     = 4'b0;
    end else begin
      n++;
      exp_done = prev_fdone && (active == CALL_WR || active == CALL_RD);
      if (oDone || exp_done) check_eq("done_pulse", 32'(oDone), 32'(exp_done));
      if (oDone) done_cnt++;
      if (prev_fdone) begin
        check_eq("fcall_drop", 32'(oFCall), 32'h0);
        if (active == CALL_INIT) begin
          check_eq("ready_after_init", 32'(oReady), 32'h1);
          run      = 1'b1;
          n        = 0;
          consumed = 0;
        end
        active = 4'b0;
      end
      if (oFCall != 4'b0 && prev_fcall == 4'b0) begin
        if (!run)                               exp_call = CALL_INIT;
        else if ((n - 1) / TREF_I > consumed)   exp_call = CALL_REF;
        else if (prev_icall[1])                 exp_call = CALL_WR;
        else if (prev_icall[0])                 exp_call = CALL_RD;
        else                                    exp_call = 4'b0;
        check_eq("fcall_pick", 32'(oFCall), 32'(exp_call));
        if (oFCall == CALL_REF) begin
          consumed = (n - 1) / TREF_I;
          ref_times.push_back(n);
        end
        if (oFCall == CALL_WR) begin
          check_eq("faddr_wr", 32'(oFAddr), 32'(iAddr));
          check_eq("fdata_wr", 32'(oFData), 32'(iData));
        end
        if (oFCall == CALL_RD) check_eq("faddr_rd", 32'(oFAddr), 32'(iAddr));
        if (oFCall == CALL_WR || oFCall == CALL_RD) last_user = oFCall;
        if (run) call_log.push_back(oFCall);
        active = oFCall;
      end
      prev_fcall = oFCall;
      prev_icall = iCall;
      prev_fdone = iFDone;
    end
  end

  int exp_dones = 0;

  // Hold the remaining request bits until each sees its oDone
  task automatic serve(input logic [1:0] kind, input logic [23:0] a, input logic [15:0] d);
    logic [1:0] left;
    int         budget;
    left   = kind;
    budget = 0;
    while (left != 2'b0 && budget < 600) begin
      @(negedge CLOCK);
      budget++;
      if (oDone) begin
        if (last_user == CALL_WR) begin
          ref_mem[a] = d;
          left[1]    = 1'b0;
        end else begin
          check_eq("rd_data", 32'(oData), 32'(ref_mem[a]));
          left[0] = 1'b0;
        end
        @(posedge CLOCK);
        #1;
        iCall = left;
      end
    end
    if (left != 2'b0) begin
      check_eq("op_timeout", 32'(left), 32'h0);
      iCall = 2'b0;
    end
    exp_dones += int'(kind[1]) + int'(kind[0]);
  endtask

  task automatic do_op(input logic [1:0] kind, input logic [23:0] a, input logic [15:0] d);
    @(posedge CLOCK);
    #1;
    iAddr = a;
    iData = d;
    iCall = kind;
    serve(kind, a, d);
  endtask

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (oReady !== 1'b1 && budget < 300) begin
      @(negedge CLOCK);
      budget++;
    end
    check_eq("wait_ready", 32'(oReady), 32'h1);
  endtask

  task automatic wait_fcall(input logic [3:0] c);
    int budget;
    budget = 0;
    while (oFCall !== c && budget < 300) begin
      @(negedge CLOCK);
      budget++;
    end
    check_eq("wait_fcall", 32'(oFCall), 32'(c));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_fcall"}, 32'(oFCall), 32'h0);
    check_eq({tag, "_done"},  32'(oDone),  32'h0);
    check_eq({tag, "_ready"}, 32'(oReady), 32'h0);
    check_eq({tag, "_data"},  32'(oData),  32'h0);
    check_eq({tag, "_faddr"}, 32'(oFAddr), 32'h0);
    check_eq({tag, "_fdata"}, 32'(oFData), 32'h0);
  endtask

  logic [3:0]  users [$];
  logic [23:0] a;
  logic [15:0] d;
  int          s, e, d0;

  initial begin
    iCall = 2'b0;
    iAddr = 24'h0;
    iData = 16'h0;
    for (int i = 0; i < 8; i++) begin
      addr_tab[i] = {2'(i % 4), 13'(i * 37 + 5), 9'(i * 11)};
      fmem[addr_tab[i]]    = 16'h0;
      ref_mem[addr_tab[i]] = 16'h0;
    end
    fmem[24'h40_0123]    = 16'h0;
    ref_mem[24'h40_0123] = 16'h0;

    // Reset values, then init call
    repeat (3) @(negedge CLOCK);
    check_reset_vals("rst");
    RESET = 1'b1;
    @(negedge CLOCK);
    check_eq("init_call", 32'(oFCall), 32'(CALL_INIT));
    wait_ready();
    check_eq("init_no_done", 32'(done_cnt), 32'h0);

    // Directed write then read-back
    do_op(2'b10, 24'h40_0123, 16'hA5C3);
    do_op(2'b01, 24'h40_0123, 16'h0000);
    check_eq("rd_a5c3", 32'(oData), 32'hA5C3);

    // Simultaneous write and read: write first, read next, two dones
    call_log.delete();
    d0 = done_cnt;
    do_op(2'b11, addr_tab[3], 16'h1234);
    users.delete();
    foreach (call_log[i]) if (call_log[i] != CALL_REF) users.push_back(call_log[i]);
    check_eq("sim_count", 32'(users.size()), 32'h2);
    if (users.size() == 2) begin
      check_eq("sim_first",  32'(users[0]), 32'(CALL_WR));
      check_eq("sim_second", 32'(users[1]), 32'(CALL_RD));
    end
    check_eq("sim_dones", 32'(done_cnt - d0), 32'h2);
    check_eq("sim_rd", 32'(oData), 32'h1234);

    // Idle refresh cadence
    s = ref_times.size();
    repeat (4 * TREF_I + 5) @(negedge CLOCK);
    e = ref_times.size();
    check_eq("ref_count", 32'(e - s >= 3), 32'h1);
    for (int i = s + 1; i < e; i++)
      check_eq("ref_interval", 32'(ref_times[i] - ref_times[i-1]), 32'(TREF_I));

    // Long read spanning two timer wraps, write raised meanwhile
    s = ref_times.size();
    for (int i = 0; i < 2 * TREF_I && ref_times.size() == s; i++) @(negedge CLOCK);
    repeat (15) @(negedge CLOCK);
    wait_ready();
    call_log.delete();
    a = addr_tab[5];
    force_lat = 2 * TREF_I + 10;
    @(posedge CLOCK);
    #1;
    iAddr = a;
    iCall = 2'b01;
    wait_fcall(CALL_RD);
    @(posedge CLOCK);
    #1;
    force_lat = 0;
    iData = 16'hBEEF;
    iCall = 2'b11;
    serve(2'b11, a, 16'hBEEF);
    check_eq("long_log_len", 32'(call_log.size()), 32'h3);
    if (call_log.size() == 3) begin
      check_eq("long_log0", 32'(call_log[0]), 32'(CALL_RD));
      check_eq("long_log1", 32'(call_log[1]), 32'(CALL_REF));
      check_eq("long_log2", 32'(call_log[2]), 32'(CALL_WR));
    end

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      do_op(2'($urandom_range(1, 3)), addr_tab[$urandom_range(0, 7)], 16'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge CLOCK);
    end
    check_eq("done_total", 32'(done_cnt), 32'(exp_dones));

    // Reset in the middle of a write
    force_lat = 40;
    @(posedge CLOCK);
    #1;
    iAddr = addr_tab[1];
    iData = 16'h5A5A;
    iCall = 2'b10;
    wait_fcall(CALL_WR);
    repeat (5) @(negedge CLOCK);
    RESET = 1'b0;
    iCall = 2'b0;
    force_lat = 0;
    d0 = done_cnt;
    @(negedge CLOCK);
    check_reset_vals("midrst");
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    check_eq("reinit_call", 32'(oFCall), 32'(CALL_INIT));
    wait_ready();
    repeat (5) @(negedge CLOCK);
    check_eq("reinit_no_done", 32'(done_cnt - d0), 32'h0);
    do_op(2'b01, addr_tab[1], 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
